avalon_ram_slave: RTL and testbench

- Avalon-MM slave memory sitting directly downstream of mips_cpu_bus; it serves the CPU's instruction and data accesses.
- Replaces the zero-wait combinational RAM model in CPU benches with a clocked model that inserts wait states and applies byte lanes.
- Maps a low data region and a boot region at the MIPS reset vector onto one word array.
- Provides a combinational debug read port so benches can compare final memory contents against an expected image.

---
 rtl/avalon_ram_if.sv | 27 ++
 rtl/avalon_ram_slave.sv | 136 +++++++++++++
 tb/tb_avalon_ram_slave.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_if.sv
// avalon_ram_if
//   Avalon-MM bus bundle between a CPU-side master and a RAM slave.
//   address     byte address (bits [1:0] ignored by the slave)
//   read/write  transfer requests, held until waitrequest drops
//   byteenable  lane enables, bit3 = [31:24] ... bit0 = [7:0]
//   writedata   write payload
//   waitrequest slave stall
//   readdata    read payload, valid in the completion cycle
interface avalon_ram_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata
   );
endinterface

// File: rtl/avalon_ram_slave.sv
// avalon_ram_slave
//   Clocked Avalon-MM RAM model with fixed wait states and byte lanes.
//   A low data region and a boot region at BOOT_BASE share one word array.
//   Ports:
//     clk       clock, all state changes on posedge
//     reset     synchronous, active-high; never clears the array
//     bus       avalon_ram_if slave modport
//     err       sticky protocol / range error
//     dbg_addr  debug byte address, same mapping as the bus
//     dbg_data  combinational array word at dbg_addr, 0 when unmapped
module avalon_ram_slave #(
   parameter int          DATA_WORDS  = 2048,
   parameter logic [31:0] BOOT_BASE   = 32'hBFC00000,
   parameter int          BOOT_WORDS  = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter string       RAM_FILE    = ""
) (
   input  logic               clk,
   input  logic               reset,
   avalon_ram_if.slave        bus,
   output logic               err,
   input  logic [31:0]        dbg_addr,
   output logic [31:0]        dbg_data
);

   localparam int          TOTAL_WORDS = DATA_WORDS + BOOT_WORDS;
   localparam int          IDX_W       = $clog2(TOTAL_WORDS);
   localparam logic [31:0] DATA_BYTES  = 32'(4 * DATA_WORDS);
   localparam logic [31:0] BOOT_BYTES  = 32'(4 * BOOT_WORDS);
   localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_CYCLES);

   // Returns {in_range, array index}.
   function automatic logic [IDX_W:0] map_addr(input logic [31:0] a);
      logic [31:0] off;
      off      = a - BOOT_BASE;
      map_addr = '0;
      if (a < DATA_BYTES) begin
         map_addr = {1'b1, IDX_W'(a[31:2])};
      end else if (a >= BOOT_BASE && off < BOOT_BYTES) begin
         map_addr = {1'b1, IDX_W'(DATA_WORDS) + IDX_W'(off[31:2])};
      end
   endfunction

   logic [31:0]      mem_q [TOTAL_WORDS];

   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      last_addr_q, last_addr_d;
   logic             last_rd_q, last_rd_d;
   logic             last_wr_q, last_wr_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             req, wait_req, done, changed, both;
   logic             bus_ok, dbg_ok;
   logic [IDX_W-1:0] bus_idx, dbg_idx;
   logic [31:0]      lane_mask;

   initial begin
      for (int i = 0; i < TOTAL_WORDS; i++) mem_q[i] = '0;
   end

   assign {bus_ok, bus_idx} = map_addr(bus.address);
   assign {dbg_ok, dbg_idx} = map_addr(dbg_addr);

   assign req      = bus.read | bus.write;
   assign both     = bus.read & bus.write;
   assign wait_req = req & (cnt_q != WAIT_LAST);
   assign done     = req & ~wait_req;
   assign changed  = {bus.address, bus.read, bus.write} !=
                     {last_addr_q, last_rd_q, last_wr_q};

   assign lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                       {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

   always_comb begin
      cnt_d       = cnt_q;
      last_addr_d = last_addr_q;
      last_rd_d   = last_rd_q;
      last_wr_d   = last_wr_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      if (req) begin
         last_addr_d = bus.address;
         last_rd_d   = bus.read;
         last_wr_d   = bus.write;
         if (done) begin
            cnt_d = '0;
         end else if (changed && cnt_q != 4'd0) begin
            // Master changed the request mid-transfer: restart on the new one.
            cnt_d = 4'd1;
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         // Read data is refreshed every wait cycle so it is stable at completion.
         if (bus.read && wait_req) begin
            rdata_d = (bus_ok && !bus.write) ? (mem_q[bus_idx] & lane_mask) : '0;
         end
         if (done && (!bus_ok || both)) err_d = 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         last_addr_q <= '0;
         last_rd_q   <= 1'b0;
         last_wr_q   <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         last_addr_q <= last_addr_d;
         last_rd_q   <= last_rd_d;
         last_wr_q   <= last_wr_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always @(posedge clk) begin
      if (!reset && done && bus.write && !bus.read && bus_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) mem_q[bus_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
         end
      end
   end

   assign bus.waitrequest = wait_req;
   assign bus.readdata    = rdata_q;
   assign err             = err_q;
   assign dbg_data        = dbg_ok ? mem_q[dbg_idx] : '0;

endmodule

// File: tb/tb_avalon_ram_slave.sv
module tb_avalon_ram_slave;
   localparam int          DW = 2048;
   localparam int          BW = 256;
   localparam logic [31:0] BB = 32'hBFC00000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   avalon_ram_if bus_a();
   avalon_ram_if bus_b();

   int          sel = 0;
   logic [31:0] t_addr = '0, t_wd = '0, dbg_addr = '0;
   logic        t_rd = 1'b0, t_wr = 1'b0;
   logic [3:0]  t_be = '0;
   logic        err_a, err_b;
   logic [31:0] dbg_a, dbg_b;

   assign bus_a.address    = t_addr;
   assign bus_a.read       = (sel == 0) && t_rd;
   assign bus_a.write      = (sel == 0) && t_wr;
   assign bus_a.byteenable = t_be;
   assign bus_a.writedata  = t_wd;
   assign bus_b.address    = t_addr;
   assign bus_b.read       = (sel == 1) && t_rd;
   assign bus_b.write      = (sel == 1) && t_wr;
   assign bus_b.byteenable = t_be;
   assign bus_b.writedata  = t_wd;

   wire        wreq   = (sel != 0) ? bus_b.waitrequest : bus_a.waitrequest;
   wire [31:0] rd_mux = (sel != 0) ? bus_b.readdata : bus_a.readdata;
   wire        e_mux  = (sel != 0) ? err_b : err_a;
   wire [31:0] d_mux  = (sel != 0) ? dbg_b : dbg_a;

   avalon_ram_slave #(.WAIT_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .err(err_a),
      .dbg_addr(dbg_addr), .dbg_data(dbg_a));

   avalon_ram_slave #(.WAIT_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .err(err_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: word store keyed by (dut, index), readdata and err per dut.
   bit [31:0]   ref_mem [int];
   logic [31:0] ref_rd [2];
   bit          ref_err [2];
   bit          x_ok;
   int          x_idx;

   function automatic bit map(input logic [31:0] a, output int idx);
      longint ua = longint'(a);
      idx = -1;
      if (ua < 4 * DW) begin
         idx = int'(ua / 4);
         return 1'b1;
      end
      if (ua >= longint'(BB) && ua < longint'(BB) + 4 * BW) begin
         idx = DW + int'((ua - longint'(BB)) / 4);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] word(input int idx);
      int key = sel * 65536 + idx;
      return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
   endfunction

   function automatic logic [31:0] mask(input logic [3:0] be);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic start_xfer(input bit r, input bit w, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d);
      t_rd = r; t_wr = w; t_addr = a; t_be = be; t_wd = d;
      x_ok = map(a, x_idx);
      if (r) ref_rd[sel] = (x_ok && !w) ? (word(x_idx) & mask(be)) : 32'h0;
   endtask

   task automatic finish_xfer(input string tag);
      int n;
      int wc = (sel != 0) ? 1 : 2;
      logic [31:0] nw;
      #1;
      n = 1;
      while (wreq && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(wc + 1));
      chk({tag, "_rdata"}, rd_mux, ref_rd[sel]);
      @(posedge clk); #1;
      if (x_ok && t_wr && !t_rd) begin
         nw = word(x_idx);
         for (int i = 0; i < 4; i++) if (t_be[i]) nw[8*i +: 8] = t_wd[8*i +: 8];
         ref_mem[sel * 65536 + x_idx] = nw;
      end
      if (!x_ok || (t_rd && t_wr)) ref_err[sel] = 1'b1;
      chk({tag, "_err"}, 32'(e_mux), 32'(ref_err[sel]));
      if (x_ok) begin
         dbg_addr = t_addr; #1;
         chk({tag, "_dbg"}, d_mux, word(x_idx));
      end
   endtask

   task automatic do_xfer(input bit r, input bit w, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d, input string tag);
      start_xfer(r, w, a, be, d);
      finish_xfer(tag);
   endtask

   task automatic idle();
      t_rd = 1'b0; t_wr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      t_rd = 1'b0; t_wr = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_rd[0] = '0; ref_rd[1] = '0;
      ref_err[0] = 1'b0; ref_err[1] = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 7))
         0, 1, 2: a = 32'(4 * $urandom_range(0, 31));
         3:       a = 32'(4 * $urandom_range(DW - 2, DW - 1));
         4, 5:    a = BB + 32'(4 * $urandom_range(0, 7));
         6:       a = BB + 32'(4 * $urandom_range(BW - 2, BW - 1));
         default: case ($urandom_range(0, 3))
                     0: a = 32'(4 * DW);
                     1: a = BB - 32'd4;
                     2: a = BB + 32'(4 * BW);
                     default: a = 32'hFFFF_FFFC;
                  endcase
      endcase
      return a | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      ref_rd[0] = '0; ref_rd[1] = '0;
      ref_err[0] = 1'b0; ref_err[1] = 1'b0;

      // Reset state: waitrequest follows req, readdata and err cleared.
      @(posedge clk); #1;
      t_rd = 1'b1; #1;
      chk("rst_wreq_req", 32'(wreq), 32'd1);
      chk("rst_rdata", rd_mux, 32'h0);
      chk("rst_err", 32'(e_mux), 32'd0);
      t_rd = 1'b0; #1;
      chk("rst_wreq_idle", 32'(wreq), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Preload the image over the bus.
      do_xfer(0, 1, 32'h0,    4'hF, 32'h8C020004, "pre0");
      do_xfer(0, 1, BB + 4,   4'hF, 32'h24020005, "preboot");
      do_xfer(0, 1, 32'h40,   4'hF, 32'h11223344, "pre40");
      do_xfer(0, 1, 32'h4,    4'hF, 32'hCAFEF00D, "pre4");
      idle();

      do_xfer(1, 0, 32'h0, 4'hF, 32'h0, "rd0");
      chk("rd0_val", rd_mux, 32'h8C020004);
      do_xfer(1, 0, BB + 4, 4'hF, 32'h0, "rdboot");
      chk("rdboot_val", rd_mux, 32'h24020005);

      do_xfer(0, 1, 32'h40, 4'b0101, 32'hAABBCCDD, "lanew");
      dbg_addr = 32'h40; #1;
      chk("lanew_val", d_mux, 32'h11BB33DD);
      do_xfer(1, 0, 32'h40, 4'b0011, 32'h0, "laner");
      chk("laner_val", rd_mux, 32'h000033DD);
      do_xfer(0, 1, 32'h40, 4'b0000, 32'hFFFFFFFF, "be0");
      chk("be0_noerr", 32'(e_mux), 32'd0);

      do_xfer(1, 0, BB + 32'(4 * BW), 4'hF, 32'h0, "oor");
      chk("oor_rd", rd_mux, 32'h0);
      chk("oor_err", 32'(e_mux), 32'd1);

      // Reset in the second cycle of a write: nothing commits, held request restarts.
      do_reset();
      start_xfer(0, 1, 32'h8, 4'hF, 32'hFFFFFFFF);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_rd[0] = '0; ref_err[0] = 1'b0;
      dbg_addr = 32'h8; #1;
      chk("rstmid_word", d_mux, 32'h0);
      chk("rstmid_rd", rd_mux, 32'h0);
      chk("rstmid_err", 32'(e_mux), 32'd0);
      t_addr = 32'h8;
      finish_xfer("rstmid_hold");

      do_xfer(1, 1, 32'h40, 4'hF, 32'h0, "both");
      chk("both_err", 32'(e_mux), 32'd1);
      chk("both_word", d_mux, 32'h11BB33DD);

      // Address changes from 0 to 4 during the wait.
      do_reset();
      start_xfer(1, 0, 32'h0, 4'hF, 32'h0);
      @(posedge clk); #1;
      start_xfer(1, 0, 32'h4, 4'hF, 32'h0);
      ref_err[0] = 1'b1;
      finish_xfer("addrchg");
      chk("addrchg_val", rd_mux, 32'hCAFEF00D);
      idle();

      // Back-to-back on the single-wait-state instance.
      sel = 1;
      do_xfer(0, 1, 32'h20, 4'hF, 32'h12345678, "b2bw");
      do_xfer(1, 0, 32'h20, 4'hF, 32'h0, "b2br");
      chk("b2b_val", rd_mux, 32'h12345678);
      idle();

      // Randomized traffic on both instances.
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            k = int'($urandom_range(0, 15));
            do_xfer(k <= 7, k == 0 || k >= 8, rand_addr(), 4'($urandom_range(0, 15)),
                    $urandom, "rnd");
         end
         idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
